barret_1667_rr_sched: RTL and testbench

Round-robin scheduler that shares one 3-stage pipelined Barrett reduction datapath (modulus 1667) among NUM_REQ requesters.
- Each requester presents a 21-bit operand with a valid/ready handshake.
- At most one operand is granted per cycle.
- Results leave in order on a single response port, tagged with the requester index, under valid/ready backpressure.
- Sits between the polynomial-multiply producers and the coefficient writeback in the mod-1667 arithmetic path.

---
 rtl/barret_1667_rr_sched.sv | 212 +++++++++++++++++++++
 tb/tb_barret_1667_rr_sched.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barret_1667_rr_sched.sv
// -----------------------------------------------------------------------------
// barret_1667_rr_sched
//
// Round-robin scheduler in front of a shared 3-stage Barrett reduction
// pipeline (modulus 1667). NUM_REQ requesters offer 21-bit operands, and at
// most one operand is accepted per cycle. Results leave in grant order on a
// single response port, tagged with the originating requester index.
//
// Ports
//   clk        : clock, all state on the rising edge
//   rst_n      : asynchronous active-low reset
//   flush      : synchronous clear of pipeline valids and the RR pointer
//   req_valid  : per-requester operand valid
//   req_data   : packed operands, requester i at [21i+20:21i]
//   req_ready  : one-hot grant (only ever set on a valid requester)
//   resp_valid : result valid
//   resp_ready : downstream accept
//   resp_data  : operand mod 1667, in 0..1666
//   resp_id    : index of the originating requester
//   inflight   : number of occupied pipeline stages (0..3)
// -----------------------------------------------------------------------------
module barret_1667_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*21-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [10:0]           resp_data,
  output logic [ID_W-1:0]       resp_id,
  output logic [2:0]            inflight
);

  localparam int X_W   = 21;
  localparam int P_W   = 22;
  localparam int R_W   = 11;
  localparam int CNT_W = ID_W + 1;

  // Pointer parks on the last requester so requester 0 wins first.
  localparam logic [ID_W-1:0] PTR_INIT = ID_W'(NUM_REQ - 1);

  // Barrett constants: 2516 = floor(2^22 / 1667), split as two 11-bit shifts.
  localparam logic [P_W-1:0] MU      = 22'd2516;
  localparam logic [X_W-1:0] MOD     = 21'd1667;
  localparam logic [X_W-1:0] MOD_X2  = 21'd3334;

  // State
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            v1_q, v1_d;
  logic [X_W-1:0]  x1_q, x1_d;
  logic [ID_W-1:0] id1_q, id1_d;
  logic [P_W-1:0]  p1_q, p1_d;
  logic            v2_q, v2_d;
  logic [X_W-1:0]  x2_q, x2_d;
  logic [ID_W-1:0] id2_q, id2_d;
  logic [X_W-1:0]  m2_q, m2_d;
  logic            resp_valid_q, resp_valid_d;
  logic [R_W-1:0]  resp_data_q, resp_data_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;

  // Combinational helpers
  logic            stall;
  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [CNT_W-1:0] cand;
  logic            grant_en;
  logic [X_W-1:0]  op_x;
  logic [P_W-1:0]  p_in;
  logic [X_W-1:0]  m_in;
  logic [X_W-1:0]  r_raw;
  logic [X_W-1:0]  r_fold;

  // The output register is the last stage; a held response freezes everything.
  assign stall = resp_valid_q & ~resp_ready;

  // Round-robin search: first valid requester at ptr+1, ptr+2, ... mod NUM_REQ.
  always_comb begin : rr_search
    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + CNT_W'(i);
      if (cand >= CNT_W'(NUM_REQ)) begin
        cand = cand - CNT_W'(NUM_REQ);
      end
      if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
  end

  // No grant during reset, flush or stall, so an offered operand is never lost.
  assign grant_en = rst_n & ~flush & ~stall & gnt_found;

  always_comb begin : ready_decode
    req_ready = '0;
    if (grant_en) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign op_x = req_data[X_W*int'(gnt_idx) +: X_W];

  // Quotient estimate; p needs the full 22 bits (max 1023*2516).
  assign p_in = P_W'(op_x[20:11]) * MU;
  assign m_in = X_W'(p1_q[21:11]) * MOD;

  // Estimate is short by at most two moduli, so r sits in [0, 3*1667).
  always_comb begin : fold
    r_raw = x2_q - m2_q;
    if (r_raw >= MOD_X2) begin
      r_fold = r_raw - MOD_X2;
    end else if (r_raw >= MOD) begin
      r_fold = r_raw - MOD;
    end else begin
      r_fold = r_raw;
    end
  end

  always_comb begin : next_state
    ptr_d        = ptr_q;
    v1_d         = v1_q;
    x1_d         = x1_q;
    id1_d        = id1_q;
    p1_d         = p1_q;
    v2_d         = v2_q;
    x2_d         = x2_q;
    id2_d        = id2_q;
    m2_d         = m2_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;

    if (flush) begin
      // Flush outranks stall: a held response is discarded too.
      v1_d         = 1'b0;
      v2_d         = 1'b0;
      resp_valid_d = 1'b0;
      ptr_d        = PTR_INIT;
    end else if (!stall) begin
      v1_d = grant_en;
      if (grant_en) begin
        x1_d  = op_x;
        id1_d = gnt_idx;
        p1_d  = p_in;
        ptr_d = gnt_idx;
      end

      v2_d = v1_q;
      if (v1_q) begin
        x2_d  = x1_q;
        id2_d = id1_q;
        m2_d  = m_in;
      end

      // Bubbles keep the last result on resp_data but never raise resp_valid.
      resp_valid_d = v2_q;
      if (v2_q) begin
        resp_data_d = R_W'(r_fold);
        resp_id_d   = id2_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours and the stages shift cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset as well, because resp_data and
      // resp_id must read zero straight out of reset.
      ptr_q        <= PTR_INIT;
      v1_q         <= 1'b0;
      x1_q         <= '0;
      id1_q        <= '0;
      p1_q         <= '0;
      v2_q         <= 1'b0;
      x2_q         <= '0;
      id2_q        <= '0;
      m2_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
    end else begin
      ptr_q        <= ptr_d;
      v1_q         <= v1_d;
      x1_q         <= x1_d;
      id1_q        <= id1_d;
      p1_q         <= p1_d;
      v2_q         <= v2_d;
      x2_q         <= x2_d;
      id2_q        <= id2_d;
      m2_q         <= m2_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign inflight   = {2'b00, v1_q} + {2'b00, v2_q} + {2'b00, resp_valid_q};

endmodule

// File: tb/tb_barret_1667_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_barret_1667_rr_sched
//
// Bench for barret_1667_rr_sched. Inputs change just after the falling edge,
// outputs are sampled 1 ns later. A reference model (three-slot latency line
// holding x % 1667 and the requester id, plus a round-robin pointer) predicts
// req_ready, resp_valid/data/id and inflight every cycle. Directed sections
// then compare the observed grant and response streams with fixed constants.
// -----------------------------------------------------------------------------
module tb_barret_1667_rr_sched;

  localparam int N    = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [N-1:0]      req_valid;
  logic [N*21-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [10:0]       resp_data;
  logic [ID_W-1:0]   resp_id;
  logic [2:0]        inflight;

  barret_1667_rr_sched #(.NUM_REQ(N), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .inflight   (inflight)
  );

  always #5 clk = ~clk;

  // Counters
  int n_checks = 0;
  int n_fail   = 0;

  // Requester operands
  int unsigned req_x [N];

  // Reference model: slot 0 = S1, slot 2 = output register
  bit mv  [3];
  int md  [3];
  int mid [3];
  int m_ptr;

  // Logs of observed handshakes
  int last_gnt;
  int gnt_log   [$];
  int rsp_d_log [$];
  int rsp_id_log[$];

  int t1_ops [5] = '{0, 1666, 1667, 1667005, 2097151};
  int t1_exp [5] = '{0, 1666, 0, 5, 65};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      mv[s]  = 1'b0;
      md[s]  = 0;
      mid[s] = 0;
    end
    m_ptr = N - 1;
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    rsp_d_log.delete();
    rsp_id_log.delete();
  endtask

  // One clock cycle: caller has set inputs at the falling edge.
  task automatic step();
    int           exp_g;
    int           g;
    int           idx;
    bit           stall;
    logic [N-1:0] exp_rdy;
    for (int i = 0; i < N; i++) req_data[i*21 +: 21] = req_x[i][20:0];
    #1;
    stall = mv[2] && !resp_ready;
    check("resp_valid", {31'd0, resp_valid}, {31'd0, mv[2]});
    check("inflight", {29'd0, inflight}, 32'(int'(mv[0]) + int'(mv[1]) + int'(mv[2])));
    if (mv[2]) begin
      check("resp_data", {21'd0, resp_data}, md[2]);
      check("resp_id", {30'd0, resp_id}, mid[2]);
    end

    exp_g = -1;
    if (!flush && !stall) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (exp_g < 0 && req_valid[idx]) exp_g = idx;
      end
    end
    exp_rdy = '0;
    if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
    check("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});

    g = -1;
    for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) g = i;
    last_gnt = g;
    if (g >= 0) gnt_log.push_back(g);
    if (resp_valid && resp_ready) begin
      rsp_d_log.push_back(int'(resp_data));
      rsp_id_log.push_back(int'(resp_id));
    end

    if (flush) begin
      for (int s = 0; s < 3; s++) mv[s] = 1'b0;
      m_ptr = N - 1;
    end else if (!stall) begin
      for (int s = 2; s > 0; s--) begin
        mv[s]  = mv[s-1];
        md[s]  = md[s-1];
        mid[s] = mid[s-1];
      end
      mv[0] = (exp_g >= 0);
      if (exp_g >= 0) begin
        md[0]  = int'(req_x[exp_g] % 1667);
        mid[0] = exp_g;
        m_ptr  = exp_g;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n);
    req_valid = '0;
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic flush_step();
    flush     = 1'b1;
    req_valid = '0;
    step();
    flush = 1'b0;
  endtask

  function automatic int unsigned rand_operand();
    int unsigned sel;
    sel = $urandom_range(0, 15);
    case (sel)
      0:       return 0;
      1:       return 2097151;
      2:       return 1667 * $urandom_range(0, 1258);
      default: return $urandom & 32'h001F_FFFF;
    endcase
  endfunction

  initial begin
    int k;
    int got;
    logic [10:0]     held_d;
    logic [ID_W-1:0] held_id;

    rst_n      = 1'b0;
    flush      = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++) req_x[i] = 0;
    req_data   = '0;
    model_reset();

    // Reset state
    #2;
    check("rst_resp_valid", {31'd0, resp_valid}, 0);
    check("rst_resp_data", {21'd0, resp_data}, 0);
    check("rst_resp_id", {30'd0, resp_id}, 0);
    check("rst_inflight", {29'd0, inflight}, 0);
    req_valid = '1;
    #1;
    check("rst_req_ready", {28'd0, req_ready}, 0);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: requester 0 alone, edge operands back-to-back
    clear_logs();
    k = 0;
    for (int c = 0; c < 12; c++) begin
      req_valid = (k < 5) ? 4'b0001 : 4'b0000;
      req_x[0]  = t1_ops[(k < 5) ? k : 4];
      step();
      if (last_gnt == 0) k++;
    end
    check("t1_ngrant", gnt_log.size(), 5);
    check("t1_nresp", rsp_d_log.size(), 5);
    for (int i = 0; i < 5 && i < rsp_d_log.size(); i++) begin
      check("t1_data", rsp_d_log[i], t1_exp[i]);
      check("t1_id", rsp_id_log[i], 0);
    end

    // 2: all requesters valid, RR order 0,1,2,3,...
    flush_step();
    clear_logs();
    for (int i = 0; i < N; i++) req_x[i] = 1000 + i;
    req_valid = '1;
    for (int c = 0; c < 12; c++) step();
    idle_steps(4);
    check("t2_ngrant", gnt_log.size(), 12);
    check("t2_nresp", rsp_d_log.size(), 12);
    for (int i = 0; i < 12 && i < gnt_log.size() && i < rsp_d_log.size(); i++) begin
      check("t2_grant", gnt_log[i], i % N);
      check("t2_id", rsp_id_log[i], i % N);
      check("t2_data", rsp_d_log[i], 1000 + (i % N));
    end

    // 3: backpressure with a full pipeline
    flush_step();
    clear_logs();
    req_valid = '1;
    for (int c = 0; c < 3; c++) step();
    resp_ready = 1'b0;
    #1;
    held_d  = resp_data;
    held_id = resp_id;
    check("t3_full_valid", {31'd0, resp_valid}, 1);
    for (int c = 0; c < 5; c++) begin
      step();
      #1;
      check("t3_hold_valid", {31'd0, resp_valid}, 1);
      check("t3_hold_data", {21'd0, resp_data}, {21'd0, held_d});
      check("t3_hold_id", {30'd0, resp_id}, {30'd0, held_id});
      check("t3_hold_inflight", {29'd0, inflight}, 3);
    end
    resp_ready = 1'b1;
    idle_steps(4);
    check("t3_ngrant", gnt_log.size(), 3);
    check("t3_nresp", rsp_d_log.size(), 3);
    for (int i = 0; i < 3 && i < rsp_d_log.size(); i++) begin
      check("t3_id", rsp_id_log[i], i);
      check("t3_data", rsp_d_log[i], 1000 + i);
    end

    // 4: sparse requesters 1 and 3, then 2 joins
    flush_step();
    req_valid = 4'b0010;
    step();
    check("t4_first", last_gnt, 1);
    clear_logs();
    req_valid = 4'b1010;
    for (int c = 0; c < 4; c++) step();
    check("t4_ngrant", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
      check("t4_grant", gnt_log[i], (i % 2 == 0) ? 3 : 1);
    end
    req_valid = 4'b1110;
    got = 0;
    for (int c = 0; c < N - 1 && got == 0; c++) begin
      step();
      if (last_gnt == 2) got = 1;
    end
    check("t4_req2_granted", got, 1);
    idle_steps(4);

    // 5: flush with three operands in flight
    flush_step();
    req_valid = '1;
    for (int c = 0; c < 3; c++) step();
    #1;
    check("t5_full", {29'd0, inflight}, 3);
    flush_step();
    req_valid = '1;
    step();
    check("t5_after_first", last_gnt, 0);
    idle_steps(4);
    flush_step();
    req_valid = '1;
    #1;
    check("t5_resp_valid", {31'd0, resp_valid}, 0);
    check("t5_inflight", {29'd0, inflight}, 0);
    check("t5_ready", {28'd0, req_ready}, 4'b0001);
    step();
    idle_steps(4);

    // 6: random traffic with a mid-stream reset
    for (int i = 0; i < N; i++) req_x[i] = rand_operand();
    for (int c = 0; c < 12000; c++) begin
      if (c == 6000) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, resp_valid}, 0);
        check("t6_rst_data", {21'd0, resp_data}, 0);
        check("t6_rst_id", {30'd0, resp_id}, 0);
        check("t6_rst_inflight", {29'd0, inflight}, 0);
        check("t6_rst_ready", {28'd0, req_ready}, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      flush = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) req_valid[i] = ($urandom_range(0, 9) < 6);
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
      flush = 1'b0;
      if (last_gnt >= 0) req_x[last_gnt] = rand_operand();
    end
    resp_ready = 1'b1;
    idle_steps(5);
    #1;
    check("t6_drained", {29'd0, inflight}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
